// File: rtl/apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// apb_req_arbiter
//
// Round-robin arbiter/sequencer in front of a single apb_master transfer
// port. One request is picked in IDLE, its command is latched onto the
// master inputs, TRANSFER is pulsed for one cycle, and the arbiter then
// waits for XFER_DONE. The captured response is handed back to the winning
// requester with a one-cycle ACK.
//
// Optional feature macro: APB_ARB_TIMEOUT_EN
//   defined   : a WAIT-state watchdog ends the access after TIMEOUT cycles
//               with ERR=1 and RDATA=0 when the master never completes.
//   undefined : WAIT lasts until XFER_DONE, however long that takes.
//
// Ports
//   PCLK, PRESETn          clock, synchronous active-low reset
//   REQ, REQ_WRITE         per-requester request and direction (1=write)
//   REQ_ADDR, REQ_WDATA    packed per-requester address / write data
//   ACK                    one-hot completion pulse
//   RDATA, ERR             response, valid while ACK != 0
//   GNT                    one-hot current owner, 0 when idle
//   BUSY                   high in any state other than IDLE
//   TRANSFER               one-cycle start pulse to the master
//   READ_WRITE, PADDR_IN,
//   PWDATA_IN              latched command to the master
//   XFER_DONE, XFER_RDATA,
//   XFER_ERR               completion strobe and response from the master
// ---------------------------------------------------------------------------
module apb_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [NUM_REQ-1:0]        REQ,
  input  logic [NUM_REQ-1:0]        REQ_WRITE,
  input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
  input  logic [NUM_REQ*DATA_W-1:0] REQ_WDATA,
  output logic [NUM_REQ-1:0]        ACK,
  output logic [DATA_W-1:0]         RDATA,
  output logic                      ERR,
  output logic [NUM_REQ-1:0]        GNT,
  output logic                      BUSY,
  output logic                      TRANSFER,
  output logic                      READ_WRITE,
  output logic [ADDR_W-1:0]         PADDR_IN,
  output logic [DATA_W-1:0]         PWDATA_IN,
  input  logic                      XFER_DONE,
  input  logic [DATA_W-1:0]         XFER_RDATA,
  input  logic                      XFER_ERR
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t               state_reg, state_next;
  logic [NUM_REQ-1:0]   gnt_reg, gnt_next;
  logic [NUM_REQ-1:0]   ack_reg, ack_next;
  logic [DATA_W-1:0]    rdata_reg, rdata_next;
  logic                 err_reg, err_next;
  logic                 busy_reg, busy_next;
  logic                 transfer_reg, transfer_next;
  logic                 rw_reg, rw_next;
  logic [ADDR_W-1:0]    addr_reg, addr_next;
  logic [DATA_W-1:0]    wdata_reg, wdata_next;
  logic [IDX_W-1:0]     last_grant_reg, last_grant_next;
  logic [IDX_W-1:0]     owner_reg, owner_next;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
`endif

  // Unpack the per-requester command buses into indexable arrays.
  logic [ADDR_W-1:0] req_addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] req_wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign req_addr_arr[gi]  = REQ_ADDR[gi*ADDR_W +: ADDR_W];
    assign req_wdata_arr[gi] = REQ_WDATA[gi*DATA_W +: DATA_W];
  end

  // Round-robin pick: scan upward from the requester after the last owner,
  // wrapping, so the previous owner is considered last.
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] scan_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = IDX_W'((int'(last_grant_reg) + k) % NUM_REQ);
      if (!win_found && REQ[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    gnt_next        = gnt_reg;
    ack_next        = '0;
    rdata_next      = rdata_reg;
    err_next        = err_reg;
    transfer_next   = 1'b0;
    rw_next         = rw_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    last_grant_next = last_grant_reg;
    owner_next      = owner_reg;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_next        = cnt_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (win_found) begin
          // Command is latched here once; later REQ_* changes are ignored.
          state_next    = ST_ISSUE;
          gnt_next      = NUM_REQ'(1) << win_idx;
          owner_next    = win_idx;
          rw_next       = REQ_WRITE[win_idx];
          addr_next     = req_addr_arr[win_idx];
          wdata_next    = req_wdata_arr[win_idx];
          transfer_next = 1'b1;
        end
      end

      ST_ISSUE: begin
        state_next = ST_WAIT;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_next   = '0;
`endif
      end

      ST_WAIT: begin
        if (XFER_DONE) begin
          state_next = ST_RESP;
          ack_next   = gnt_reg;
          rdata_next = rw_reg ? '0 : XFER_RDATA;
          err_next   = XFER_ERR;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          // Master never finished: close the access with an error.
          state_next = ST_RESP;
          ack_next   = gnt_reg;
          rdata_next = '0;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
`endif
      end

      ST_RESP: begin
        state_next      = ST_IDLE;
        gnt_next        = '0;
        last_grant_next = owner_reg;
      end

      default: state_next = ST_IDLE;
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_reg      <= ST_IDLE;
      gnt_reg        <= '0;
      ack_reg        <= '0;
      rdata_reg      <= '0;
      err_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      transfer_reg   <= 1'b0;
      rw_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      last_grant_reg <= IDX_W'(NUM_REQ - 1);
      owner_reg      <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_reg        <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      gnt_reg        <= gnt_next;
      ack_reg        <= ack_next;
      rdata_reg      <= rdata_next;
      err_reg        <= err_next;
      busy_reg       <= busy_next;
      transfer_reg   <= transfer_next;
      rw_reg         <= rw_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      last_grant_reg <= last_grant_next;
      owner_reg      <= owner_next;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_reg        <= cnt_next;
`endif
    end
  end

  assign ACK        = ack_reg;
  assign RDATA      = rdata_reg;
  assign ERR        = err_reg;
  assign GNT        = gnt_reg;
  assign BUSY       = busy_reg;
  assign TRANSFER   = transfer_reg;
  assign READ_WRITE = rw_reg;
  assign PADDR_IN   = addr_reg;
  assign PWDATA_IN  = wdata_reg;

endmodule
